// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 requester bridge.
package apb3_pkg;

  localparam int unsigned ApbDataWidth   = 32;
  localparam int unsigned DefaultTimeout = 1024;
  localparam int unsigned WaitCntWidth   = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb3_state_e;

  // Saturating increment; the wait counter must never wrap back to zero.
  function automatic logic [WaitCntWidth-1:0] sat_inc(input logic [WaitCntWidth-1:0] v);
    return (v == {WaitCntWidth{1'b1}}) ? v : v + {{(WaitCntWidth-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/apb3_master_bridge.sv
// APB3 requester: turns a valid/ready command/response pair into one APB3 transfer at a time,
// honouring PREADY wait states and aborting hung slaves after a programmable timeout.
module apb3_master_bridge
  import apb3_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = DefaultTimeout
) (
  input  logic                    io_apb_PCLK,
  input  logic                    io_apb_PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ApbDataWidth-1:0] cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ApbDataWidth-1:0] rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   io_apb_PADDR,
  output logic                    io_apb_PSEL,
  output logic                    io_apb_PENABLE,
  output logic                    io_apb_PWRITE,
  output logic [ApbDataWidth-1:0] io_apb_PWDATA,
  input  logic                    io_apb_PREADY,
  input  logic [ApbDataWidth-1:0] io_apb_PRDATA,
  input  logic                    io_apb_PSLVERROR
);

  localparam logic [WaitCntWidth-1:0] TimeoutCnt = WaitCntWidth'(TIMEOUT);

  apb3_state_e             state_q;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic [ApbDataWidth-1:0] rsp_rdata_q;
  logic                    rsp_error_q;
  logic                    rsp_timeout_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [ApbDataWidth-1:0] pwdata_q;
  logic [WaitCntWidth-1:0] wait_cnt_q;
  logic                    timeout_hit;

  // Abort once TIMEOUT not-ready ACCESS cycles have elapsed; a late PREADY still wins.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TimeoutCnt);

  always_ff @(posedge io_apb_PCLK or negedge io_apb_PRESETn) begin
    if (!io_apb_PRESETn) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      wait_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            paddr_q     <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            pwrite_q    <= cmd_write;
            pwdata_q    <= cmd_wdata;
            psel_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= StAccess;
        end
        StAccess: begin
          if (io_apb_PREADY) begin
            rsp_rdata_q   <= pwrite_q ? '0 : io_apb_PRDATA;
            rsp_error_q   <= io_apb_PSLVERROR;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= StResp;
          end else if (timeout_hit) begin
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= StResp;
          end else begin
            wait_cnt_q <= sat_inc(wait_cnt_q);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign io_apb_PADDR   = paddr_q;
  assign io_apb_PSEL    = psel_q;
  assign io_apb_PENABLE = penable_q;
  assign io_apb_PWRITE  = pwrite_q;
  assign io_apb_PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench for apb3_master_bridge with a transaction-level reference model.
module tb_apb3_master_bridge;

  localparam int unsigned TbTimeout = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_checks = 0;
  int n_errors = 0;

  apb3_master_bridge #(
    .ADDR_WIDTH(16),
    .TIMEOUT   (TbTimeout)
  ) dut (
    .io_apb_PCLK     (clk),
    .io_apb_PRESETn  (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .rsp_timeout     (rsp_timeout),
    .io_apb_PADDR    (paddr),
    .io_apb_PSEL     (psel),
    .io_apb_PENABLE  (penable),
    .io_apb_PWRITE   (pwrite),
    .io_apb_PWDATA   (pwdata),
    .io_apb_PREADY   (pready),
    .io_apb_PRDATA   (prdata),
    .io_apb_PSLVERROR(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Reference model: cycles from accept edge to rsp_valid and the response fields.
  function automatic void model_xfer(input logic w, input int waits, input logic [31:0] rd,
                                     input logic err, output int lat, output logic [31:0] e_rd,
                                     output logic e_err, output logic e_tmo);
    if (waits > int'(TbTimeout)) begin
      lat = 3 + int'(TbTimeout); e_rd = 32'h0; e_err = 1'b1; e_tmo = 1'b1;
    end else begin
      lat = 3 + waits; e_rd = w ? 32'h0 : rd; e_err = err; e_tmo = 1'b0;
    end
  endfunction

  // Issues one command from IDLE and plays a slave that is ready after `waits` ACCESS cycles.
  // Returns observations only; stops in the first cycle with rsp_valid high.
  task automatic do_xfer(input logic w, input logic [15:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rd, input logic err,
                         output int lat, output int n_setup, output int n_access,
                         output bit stable);
    logic [15:0] exp_addr;
    exp_addr  = {addr[15:2], 2'b00};
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom()); cmd_addr = 16'($urandom());
    cmd_wdata = $urandom();
    lat = 1; n_setup = 0; n_access = 0; stable = 1'b1;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      if (paddr !== exp_addr || pwrite !== w || pwdata !== wdata || psel !== 1'b1) stable = 1'b0;
      if (psel === 1'b1 && penable === 1'b0) n_setup++;
      if (psel === 1'b1 && penable === 1'b1) begin
        pready  = (n_access >= waits);
        prdata  = pready ? rd : $urandom();
        pslverr = pready ? err : 1'($urandom());
        n_access++;
      end else begin
        pready = 1'($urandom()); prdata = $urandom(); pslverr = 1'($urandom());
      end
      @(posedge clk); #1;
      lat++;
    end
    pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
    #12;
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    n_checks++; if (rsp_error !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_error got=%b exp=0", rsp_error); end
    n_checks++; if (rsp_timeout !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_timeout got=%b exp=0", rsp_timeout); end
    n_checks++; if (psel !== 1'b0) begin n_errors++; $display("FAIL rst_psel got=%b exp=0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_errors++; $display("FAIL rst_penable got=%b exp=0", penable); end
    n_checks++; if (pwrite !== 1'b0) begin n_errors++; $display("FAIL rst_pwrite got=%b exp=0", pwrite); end
    n_checks++; if (paddr !== 16'h0) begin n_errors++; $display("FAIL rst_paddr got=%h exp=0", paddr); end
    n_checks++; if (pwdata !== 32'h0) begin n_errors++; $display("FAIL rst_pwdata got=%h exp=0", pwdata); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin n_errors++; $display("FAIL rst_idle got ready=%b psel=%b exp ready=1 psel=0", cmd_ready, psel); end
  endtask

  task automatic test_zero_wait_write();
    int lat, ns, na, e_lat; bit st; logic [31:0] e_rd; logic e_err, e_tmo;
    model_xfer(1'b1, 0, 32'h0, 1'b0, e_lat, e_rd, e_err, e_tmo);
    do_xfer(1'b1, 16'h1004, 32'hDEADBEEF, 0, $urandom(), 1'b0, lat, ns, na, st);
    n_checks++; if (lat !== e_lat) begin n_errors++; $display("FAIL zw_latency got=%0d exp=%0d", lat, e_lat); end
    n_checks++; if (ns !== 1 || na !== 1) begin n_errors++; $display("FAIL zw_phases got setup=%0d access=%0d exp 1/1", ns, na); end
    n_checks++; if (!st) begin n_errors++; $display("FAIL zw_stable got=0 exp=1"); end
    n_checks++; if (rsp_rdata !== e_rd || rsp_error !== e_err || rsp_timeout !== e_tmo) begin n_errors++; $display("FAIL zw_rsp got rd=%h err=%b tmo=%b exp rd=%h err=%b tmo=%b", rsp_rdata, rsp_error, rsp_timeout, e_rd, e_err, e_tmo); end
    n_checks++; if (paddr !== 16'h1004 || pwdata !== 32'hDEADBEEF || psel !== 1'b0) begin n_errors++; $display("FAIL zw_resp_bus got addr=%h wd=%h psel=%b exp 1004/deadbeef/0", paddr, pwdata, psel); end
    rsp_handshake();
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL zw_handshake got valid=%b ready=%b exp 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_wait_read();
    int lat, ns, na, e_lat; bit st; logic [31:0] e_rd; logic e_err, e_tmo;
    model_xfer(1'b0, 3, 32'h0000ABCD, 1'b0, e_lat, e_rd, e_err, e_tmo);
    do_xfer(1'b0, 16'h0024, $urandom(), 3, 32'h0000ABCD, 1'b0, lat, ns, na, st);
    n_checks++; if (lat !== e_lat) begin n_errors++; $display("FAIL wr_latency got=%0d exp=%0d", lat, e_lat); end
    n_checks++; if (na !== 4) begin n_errors++; $display("FAIL wr_access_cycles got=%0d exp=4", na); end
    n_checks++; if (!st) begin n_errors++; $display("FAIL wr_stable got=0 exp=1"); end
    n_checks++; if (rsp_rdata !== e_rd || rsp_error !== e_err || rsp_timeout !== e_tmo) begin n_errors++; $display("FAIL wr_rsp got rd=%h err=%b tmo=%b exp rd=%h err=%b tmo=%b", rsp_rdata, rsp_error, rsp_timeout, e_rd, e_err, e_tmo); end
    rsp_handshake();
  endtask

  task automatic test_slave_error();
    int lat, ns, na; bit st;
    do_xfer(1'b0, 16'h0300, $urandom(), 0, 32'h13572468, 1'b1, lat, ns, na, st);
    n_checks++; if (rsp_error !== 1'b1 || rsp_timeout !== 1'b0) begin n_errors++; $display("FAIL slverr_rsp got err=%b tmo=%b exp 1/0", rsp_error, rsp_timeout); end
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL slverr_latency got=%0d exp=3", lat); end
    rsp_handshake();
  endtask

  task automatic test_timeout();
    int lat, ns, na, e_lat; bit st; logic [31:0] e_rd; logic e_err, e_tmo;
    model_xfer(1'b0, 1000, 32'h0, 1'b0, e_lat, e_rd, e_err, e_tmo);
    do_xfer(1'b0, 16'h0800, $urandom(), 1000, 32'hFFFFFFFF, 1'b0, lat, ns, na, st);
    n_checks++; if (lat !== e_lat) begin n_errors++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, e_lat); end
    n_checks++; if (rsp_rdata !== e_rd || rsp_error !== e_err || rsp_timeout !== e_tmo) begin n_errors++; $display("FAIL tmo_rsp got rd=%h err=%b tmo=%b exp rd=%h err=%b tmo=%b", rsp_rdata, rsp_error, rsp_timeout, e_rd, e_err, e_tmo); end
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_errors++; $display("FAIL tmo_psel_drop got psel=%b pen=%b exp 0/0", psel, penable); end
    rsp_handshake();
    // PREADY arriving in the very cycle the timeout would fire counts as completion.
    model_xfer(1'b0, int'(TbTimeout), 32'hCAFE0001, 1'b0, e_lat, e_rd, e_err, e_tmo);
    do_xfer(1'b0, 16'h0804, $urandom(), int'(TbTimeout), 32'hCAFE0001, 1'b0, lat, ns, na, st);
    n_checks++; if (lat !== e_lat) begin n_errors++; $display("FAIL tmo_race_latency got=%0d exp=%0d", lat, e_lat); end
    n_checks++; if (rsp_rdata !== e_rd || rsp_error !== e_err || rsp_timeout !== e_tmo) begin n_errors++; $display("FAIL tmo_race_rsp got rd=%h err=%b tmo=%b exp rd=%h err=%b tmo=%b", rsp_rdata, rsp_error, rsp_timeout, e_rd, e_err, e_tmo); end
    rsp_handshake();
  endtask

  task automatic test_back_to_back();
    int lat, ns, na, cyc; bit st; logic [31:0] s_rd; logic s_err, s_tmo;
    do_xfer(1'b1, 16'h2008, 32'h11223344, 1, 32'h0, 1'b0, lat, ns, na, st);
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    s_rd = rsp_rdata; s_err = rsp_error; s_tmo = rsp_timeout;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0ABC; cmd_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || psel !== 1'b0) begin n_errors++; $display("FAIL bp_hold%0d got valid=%b ready=%b psel=%b exp 1/0/0", i, rsp_valid, cmd_ready, psel); end
      n_checks++; if (rsp_rdata !== s_rd || rsp_error !== s_err || rsp_timeout !== s_tmo || paddr !== 16'h2008) begin n_errors++; $display("FAIL bp_stable%0d got rd=%h err=%b tmo=%b addr=%h exp rd=%h err=%b tmo=%b addr=2008", i, rsp_rdata, rsp_error, rsp_timeout, paddr, s_rd, s_err, s_tmo); end
      @(posedge clk); #1;
    end
    rsp_handshake();
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin n_errors++; $display("FAIL bp_after_hs got valid=%b ready=%b psel=%b exp 0/1/0", rsp_valid, cmd_ready, psel); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 16'h0ABC || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL bp_second_accept got psel=%b pen=%b addr=%h ready=%b exp 1/0/0abc/0", psel, penable, paddr, cmd_ready); end
    pready = 1'b1; prdata = 32'h5A5A0001; pslverr = 1'b0; cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    pready = 1'b0;
    n_checks++; if (cyc !== 2 || rsp_rdata !== 32'h5A5A0001) begin n_errors++; $display("FAIL bp_second_rsp got cyc=%0d rd=%h exp 2/5a5a0001", cyc, rsp_rdata); end
    rsp_handshake();
  endtask

  task automatic test_reset_mid_access();
    int guard, lat, ns, na; bit st;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100; pready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; guard = 0;
    while (!(psel === 1'b1 && penable === 1'b1) && guard < 10) begin @(posedge clk); #1; guard++; end
    n_checks++; if (guard >= 10) begin n_errors++; $display("FAIL rma_reach_access got no ACCESS exp ACCESS within 10 cycles"); end
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0; #1;
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rma_async got psel=%b pen=%b valid=%b ready=%b exp 0/0/0/1", psel, penable, rsp_valid, cmd_ready); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    pready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin n_errors++; $display("FAIL rma_no_rsp got valid=%b psel=%b exp 0/0", rsp_valid, psel); end
    end
    pready = 1'b0;
    do_xfer(1'b0, 16'h0040, $urandom(), 2, 32'h12345678, 1'b0, lat, ns, na, st);
    n_checks++; if (lat !== 5 || rsp_rdata !== 32'h12345678 || rsp_error !== 1'b0) begin n_errors++; $display("FAIL rma_fresh_read got lat=%0d rd=%h err=%b exp 5/12345678/0", lat, rsp_rdata, rsp_error); end
    rsp_handshake();
  endtask

  task automatic test_random();
    int lat, ns, na, e_lat, waits, bp; bit st; logic w, err;
    logic [15:0] addr; logic [31:0] wd, rd, e_rd; logic e_err, e_tmo;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom()); addr = 16'($urandom()); wd = $urandom(); rd = $urandom();
      err = ($urandom_range(0, 3) == 0); waits = $urandom_range(0, 12);
      bp = $urandom_range(0, 2);
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rnd%0d_ready got=%b exp=1", i, cmd_ready); end
      model_xfer(w, waits, rd, err, e_lat, e_rd, e_err, e_tmo);
      do_xfer(w, addr, wd, waits, rd, err, lat, ns, na, st);
      n_checks++; if (lat !== e_lat) begin n_errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, e_lat); end
      n_checks++; if (!st || ns !== 1) begin n_errors++; $display("FAIL rnd%0d_bus got stable=%b setup=%0d exp 1/1", i, st, ns); end
      n_checks++; if (rsp_rdata !== e_rd || rsp_error !== e_err || rsp_timeout !== e_tmo) begin n_errors++; $display("FAIL rnd%0d_rsp got rd=%h err=%b tmo=%b exp rd=%h err=%b tmo=%b", i, rsp_rdata, rsp_error, rsp_timeout, e_rd, e_err, e_tmo); end
      repeat (bp) begin @(posedge clk); #1; end
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e_rd) begin n_errors++; $display("FAIL rnd%0d_held got valid=%b rd=%h exp 1/%h", i, rsp_valid, rsp_rdata, e_rd); end
      rsp_handshake();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
